// File: rtl/vx_gpr_bank_arbiter_pkg.sv
// Shared sizes, request record and bank-mapping helpers for the GPR read arbiter.
package vx_gpr_bank_arbiter_pkg;

    localparam int NUM_REQS    = 4;
    localparam int NUM_BANKS   = 4;
    localparam int NR_BITS     = 6;
    localparam int WIS_W       = 2;
    localparam int TAG_W       = 4;
    localparam int DATA_W      = 128;
    localparam int BSEL_W      = $clog2(NUM_BANKS);
    localparam int BANK_ADDR_W = WIS_W + NR_BITS - BSEL_W;
    localparam int REQ_IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef logic [BSEL_W-1:0]      bank_sel_t;
    typedef logic [BANK_ADDR_W-1:0] bank_addr_t;
    typedef logic [REQ_IDX_W-1:0]   req_idx_t;

    typedef struct packed {
        logic [NR_BITS-1:0] rid;
        logic [WIS_W-1:0]   wis;
        logic [TAG_W-1:0]   tag;
    } gpr_req_t;

    // Registers are interleaved across banks by their low id bits.
    function automatic bank_sel_t bank_of(input logic [NR_BITS-1:0] rid);
        return rid[BSEL_W-1:0];
    endfunction

    // Row inside a bank: warp index on top, remaining register id bits below.
    function automatic bank_addr_t bank_addr(input logic [WIS_W-1:0]   wis,
                                             input logic [NR_BITS-1:0] rid);
        return {wis, rid[NR_BITS-1:BSEL_W]};
    endfunction

endpackage

// File: rtl/vx_gpr_bank_arbiter_if.sv
// Request/response bus between the operand-collector slots and the GPR read arbiter.
interface vx_gpr_bank_arbiter_if;
    import vx_gpr_bank_arbiter_pkg::*;

    logic [NUM_REQS-1:0]         req_valid;
    logic [NUM_REQS*NR_BITS-1:0] req_rid;
    logic [NUM_REQS*WIS_W-1:0]   req_wis;
    logic [NUM_REQS*TAG_W-1:0]   req_tag;
    logic [NUM_REQS-1:0]         req_ready;

    logic [NUM_REQS-1:0]         rsp_valid;
    logic [NUM_REQS*TAG_W-1:0]   rsp_tag;
    logic [NUM_REQS*DATA_W-1:0]  rsp_data;

    // Collector side: issues requests, consumes responses.
    modport master (
        output req_valid, req_rid, req_wis, req_tag,
        input  req_ready, rsp_valid, rsp_tag, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_rid, req_wis, req_tag,
        output req_ready, rsp_valid, rsp_tag, rsp_data
    );

endinterface

// File: rtl/vx_rr_bank_select.sv
// Round-robin winner selection for one GPR bank; owns that bank's rr pointer.
module vx_rr_bank_select
    import vx_gpr_bank_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] cand,
    output logic [NUM_REQS-1:0] grant_oh,
    output req_idx_t            grant_idx,
    output logic                ptr_upd
);

    req_idx_t rr_ptr;
    req_idx_t scan_idx;
    req_idx_t rr_ptr_nxt;

    // Scan from the farthest position back to rr_ptr so the nearest candidate at or after rr_ptr wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        ptr_upd   = 1'b0;
        scan_idx  = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            scan_idx = req_idx_t'((int'(rr_ptr) + k) % NUM_REQS);
            if (cand[scan_idx]) begin
                grant_oh           = '0;
                grant_oh[scan_idx] = 1'b1;
                grant_idx          = scan_idx;
                ptr_upd            = 1'b1;
            end
        end
        rr_ptr_nxt = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + req_idx_t'(1);
    end

    // Pointer moves just past the winner; it holds when the bank is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (ptr_upd) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

endmodule

// File: rtl/vx_gpr_bank_arbiter.sv
// Shares the banked GPR read ports among the operand-collector requesters.
module vx_gpr_bank_arbiter
    import vx_gpr_bank_arbiter_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    vx_gpr_bank_arbiter_if.slave            gpr_if,
    output logic [NUM_BANKS-1:0]            bank_rd_en,
    output logic [NUM_BANKS*BANK_ADDR_W-1:0] bank_rd_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]     bank_rd_data,
    output logic [31:0]                     perf_conflicts
);

    gpr_req_t            req [NUM_REQS];
    logic [NUM_REQS-1:0] cand [NUM_BANKS];
    logic [NUM_REQS-1:0] grant_oh [NUM_BANKS];
    req_idx_t            grant_idx [NUM_BANKS];
    logic [NUM_BANKS-1:0] grant_any;
    logic [NUM_REQS-1:0] req_ready_c;
    logic                conflict;

    logic [NUM_REQS-1:0] vld_p1;
    bank_sel_t           bank_p1 [NUM_REQS];
    logic [TAG_W-1:0]    tag_p1 [NUM_REQS];

    // Split the flat request bus into per-requester records.
    always_comb begin
        for (int r = 0; r < NUM_REQS; r++) begin
            req[r].rid = gpr_if.req_rid[r*NR_BITS +: NR_BITS];
            req[r].wis = gpr_if.req_wis[r*WIS_W +: WIS_W];
            req[r].tag = gpr_if.req_tag[r*TAG_W +: TAG_W];
        end
    end

    // Candidates per bank; reset masks every request so nothing is granted.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            cand[b] = '0;
            for (int r = 0; r < NUM_REQS; r++) begin
                cand[b][r] = gpr_if.req_valid[r] & ~reset & (bank_of(req[r].rid) == bank_sel_t'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        vx_rr_bank_select u_sel (
            .clk       (clk),
            .reset     (reset),
            .cand      (cand[b]),
            .grant_oh  (grant_oh[b]),
            .grant_idx (grant_idx[b]),
            .ptr_upd   (grant_any[b])
        );
    end

    // Grants back to requesters and the winner's row address to each bank.
    always_comb begin
        req_ready_c  = '0;
        bank_rd_en   = '0;
        bank_rd_addr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_ready_c   = req_ready_c | grant_oh[b];
            bank_rd_en[b] = grant_any[b];
            if (grant_any[b]) begin
                bank_rd_addr[b*BANK_ADDR_W +: BANK_ADDR_W] =
                    bank_addr(req[grant_idx[b]].wis, req[grant_idx[b]].rid);
            end
        end
    end

    assign gpr_if.req_ready = req_ready_c;
    assign conflict         = |(gpr_if.req_valid & ~req_ready_c);

    // ---- stage p0 -> p1: response routing ----
    // Valid pulse and tag follow each grant by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= '0;
            for (int r = 0; r < NUM_REQS; r++) tag_p1[r] <= '0;
        end else begin
            vld_p1 <= req_ready_c;
            for (int r = 0; r < NUM_REQS; r++) begin
                if (req_ready_c[r]) tag_p1[r] <= req[r].tag;
            end
        end
    end

    // Remember which bank each granted requester read, to pick its RAM output.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REQS; r++) begin
            if (req_ready_c[r]) bank_p1[r] <= bank_of(req[r].rid);
        end
    end

    // Responses; an in-flight response is dropped while reset is high.
    always_comb begin
        gpr_if.rsp_valid = vld_p1 & ~{NUM_REQS{reset}};
        gpr_if.rsp_tag   = '0;
        gpr_if.rsp_data  = '0;
        for (int r = 0; r < NUM_REQS; r++) begin
            gpr_if.rsp_tag[r*TAG_W +: TAG_W]   = tag_p1[r];
            gpr_if.rsp_data[r*DATA_W +: DATA_W] = bank_rd_data[int'(bank_p1[r])*DATA_W +: DATA_W];
        end
    end

    // Saturating count of cycles where some valid request was left waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflicts <= '0;
        end else if (conflict && (perf_conflicts != 32'hFFFF_FFFF)) begin
            perf_conflicts <= perf_conflicts + 32'd1;
        end
    end

endmodule

// File: doc/vx_gpr_bank_arbiter.md
Name: vx_gpr_bank_arbiter

Overview:
- Shares the banked GPR read ports among NUM_REQS operand-collector requesters.
- Each request reads one register (rid, wis). The bank is selected by the low rid bits.
- Per bank, one winner per cycle, chosen round-robin.
- Read data returns to the winning requester one cycle later, tagged. The block sits between the operand-collector slots and the per-bank GPR dual-port RAMs; the write port is not touched.

Parameters:
- NUM_REQS, 4, number of requesters (collector slots).
- NUM_BANKS, 4, number of GPR banks; power of two, at least 2.
- NR_BITS, 6, register id width.
- WIS_W, 2, warp-in-slice index width.
- TAG_W, 4, opaque requester tag returned with the response.
- DATA_W, 128, read data width per bank (threads x XLEN).
- Derived: BSEL_W = log2(NUM_BANKS); BANK_ADDR_W = WIS_W + NR_BITS - BSEL_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQS  request present.
- req_rid  in  NUM_REQS*NR_BITS  register id.
- req_wis  in  NUM_REQS*WIS_W  warp index.
- req_tag  in  NUM_REQS*TAG_W  tag.
- req_ready  out  NUM_REQS  grant; handshake completes when valid and ready are both high.
- bank_rd_en  out  NUM_BANKS  bank read strobe.
- bank_rd_addr  out  NUM_BANKS*BANK_ADDR_W  bank read address = {wis, rid[NR_BITS-1:BSEL_W]}.
- bank_rd_data  in  NUM_BANKS*DATA_W  RAM read data, valid the cycle after bank_rd_en.
- rsp_valid  out  NUM_REQS  response valid; no backpressure.
- rsp_tag  out  NUM_REQS*TAG_W  tag of the granted request.
- rsp_data  out  NUM_REQS*DATA_W  register value.
- perf_conflicts  out  32  count of cycles with at least one valid-but-not-granted request.

Behaviour:
- Bank of requester r = req_rid[r][BSEL_W-1:0].
- Per bank b, the candidates are the valid requesters targeting b.
- Winner = first candidate at or after rr_ptr[b], searching upward with wrap modulo NUM_REQS.
- req_ready[r] = 1 iff r is the winner of its bank. This is combinational from req_valid/req_rid and the registered rr_ptr.
- bank_rd_en[b] = 1 iff bank b has a winner. bank_rd_addr is built from the winner's wis/rid (combinational, same cycle). When bank_rd_en=0, bank_rd_addr is 0.
- On a grant in bank b: rr_ptr[b] <= (winner+1) mod NUM_REQS. With no grant, rr_ptr[b] holds.
- Each requester targets exactly one bank, so it receives at most one grant per cycle. Up to min(NUM_REQS, NUM_BANKS) grants per cycle.
- Latency: a grant in cycle N gives rsp_valid[r]=1 in cycle N+1.
  - rsp_tag comes from a tag registered at grant.
  - rsp_data = bank_rd_data[registered bank of r].
  - The response routing registers (valid, bank, tag per requester) form a single pipeline stage.
- rsp_valid is a one-cycle pulse per handshake. A requester may issue a new request in cycle N+1; back-to-back grants to the same requester yield consecutive rsp pulses.
- Request stability: while req_valid[r]=1 and req_ready[r]=0, the requester must hold rid/wis/tag stable. The arbiter does not check this.
- Starvation bound: a waiting requester is granted within NUM_REQS-1 cycles of becoming valid, if it holds valid.
- perf_conflicts:
  - +1 in any cycle where some req_valid[r] & ~req_ready[r].
  - Saturates at 2^32-1.
  - Not incremented during reset.
- Reset:
  - rr_ptr all 0, rsp_valid 0, rsp_tag 0, perf_conflicts 0.
  - req_ready and bank_rd_en are forced to 0 while reset is high.
  - A response in flight when reset asserts is dropped; rsp_valid is 0 in the cycle after reset.
- Simultaneous events: a grant and a pointer update in the same cycle; the pointer update takes effect next cycle. Requesters on distinct banks never interact.

Decomposition:
- The shared package holds:
  - the request struct (rid, wis, tag);
  - the bank_of() and bank_addr() functions;
  - the BSEL_W/BANK_ADDR_W derivations.
- Sub-module vx_rr_bank_select (one instance per bank): takes the candidate mask and outputs a one-hot winner and the pointer update. It contains the rr_ptr register.
- The top level holds candidate mask generation, address muxing, the response pipeline and the perf counter.

Test Plan:
- Single request: r0 valid, rid=5, wis=1, tag=3 -> req_ready[0]=1 that cycle; bank_rd_en[1]=1; bank_rd_addr={1,1}. Next cycle rsp_valid[0]=1, tag=3, data = bank1 data.
- Distinct banks: r0..r3 with rid=0,1,2,3 in the same cycle -> all four ready; all bank_rd_en set; four rsp next cycle; perf_conflicts stays 0.
- Conflict round-robin: r0..r3 all hold rid=4 (bank 0) with rr_ptr=0 -> grants in order 0,1,2,3 over 4 cycles; perf_conflicts +3.
- Pointer wrap: after the previous test, r3 and r0 request bank 0 -> r0 granted first (ptr wrapped to 0), then r3.
- Reset mid-flight: grant in cycle N, reset asserted in N+1 -> rsp_valid=0 in N+1 and N+2; rr_ptr=0; perf_conflicts=0.
- Saturation/hold: force perf_conflicts to 0xFFFFFFFF, then create a conflict -> value stays 0xFFFFFFFF. Change rid of a waiting requester: the bench must flag it; the DUT is not expected to flag it.
